// File: rtl/instruction_register.sv
// Fetch-and-hold stage: issues one instruction-memory read per fetch command,
// latches the returned word into the IR and decodes it into fixed fields.
module instruction_register #(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned IMM_SIZE  = 16,
    parameter int unsigned ADDR_SIZE = 32,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_fetch_start,
    input  logic [ADDR_SIZE-1:0] i_pc_in,
    output logic                 o_mem_req,
    output logic [ADDR_SIZE-1:0] o_mem_addr,
    input  logic [WORD_SIZE-1:0] i_mem_rdata,
    input  logic                 i_mem_ready,
    output logic                 o_busy,
    output logic                 o_ir_valid,
    output logic                 o_fetch_err,
    output logic [WORD_SIZE-1:0] o_instr_out,
    output logic [5:0]           o_opcode,
    output logic [4:0]           o_rs,
    output logic [4:0]           o_rt,
    output logic [4:0]           o_rd,
    output logic [4:0]           o_shamt,
    output logic [5:0]           o_funct,
    output logic [IMM_SIZE-1:0]  o_imm,
    output logic [25:0]          o_jtarget
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [ADDR_SIZE-1:0] r_mem_addr;
    logic [WORD_SIZE-1:0] r_ir;
    logic                 r_ir_valid;
    logic                 r_fetch_err;

    // Control FSM; a capture in the last allowed wait cycle beats the timeout.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mem_addr  <= '0;
            r_ir        <= '0;
            r_ir_valid  <= 1'b0;
            r_fetch_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_fetch_start) begin
                        r_mem_addr  <= i_pc_in;
                        r_cnt       <= '0;
                        r_ir_valid  <= 1'b0;
                        r_fetch_err <= 1'b0;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_mem_ready) begin
                        r_ir       <= i_mem_rdata;
                        r_ir_valid <= 1'b1;
                        r_state    <= S_IDLE;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_fetch_err <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Handshake outputs come straight off the state register.
    assign o_mem_req   = (r_state == S_REQ);
    assign o_busy      = (r_state == S_REQ);
    assign o_mem_addr  = r_mem_addr;
    assign o_ir_valid  = r_ir_valid;
    assign o_fetch_err = r_fetch_err;

    // Field decode is pure wiring from the IR.
    assign o_instr_out = r_ir;
    assign o_opcode    = r_ir[31:26];
    assign o_rs        = r_ir[25:21];
    assign o_rt        = r_ir[20:16];
    assign o_rd        = r_ir[15:11];
    assign o_shamt     = r_ir[10:6];
    assign o_funct     = r_ir[5:0];
    assign o_imm       = r_ir[IMM_SIZE-1:0];
    assign o_jtarget   = r_ir[25:0];

endmodule
